// File: rtl/sa_row_ctrl.sv
// Row controller for one systolic-array PE row: weight load, input skew, valid-token tracking.
// Optional stall counter output enabled by defining SA_ROW_CTRL_STALL_CNT_EN.
module sa_row_ctrl #(
  parameter int DATA_BW        = 8,
  parameter int WEIGHT_BW      = 8,
  parameter int MATRIX_SIZE    = 8,
  parameter int PARTIAL_SUM_BW = 19
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  input  logic [7:0]                       num_vec,
  input  logic [MATRIX_SIZE*WEIGHT_BW-1:0] w_data,
  input  logic                             in_valid,
  input  logic [MATRIX_SIZE*DATA_BW-1:0]   in_data,
  output logic                             in_ready,
  output logic                             we_rl,
  output logic [MATRIX_SIZE*WEIGHT_BW-1:0] WEIGHTS,
  output logic [MATRIX_SIZE*DATA_BW-1:0]   DIN,
  output logic                             res_valid,
  output logic                             busy,
`ifdef SA_ROW_CTRL_STALL_CNT_EN
  output logic [15:0]                      stall_cnt,
`endif
  output logic                             done
);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t               state;
  logic [7:0]           num_vec_q;
  logic [7:0]           acc_cnt;
  logic [7:0]           res_cnt;
  logic [MATRIX_SIZE:0] token_q;
  logic                 accept;

  // The row result must be able to hold at least one full product.
  if (PARTIAL_SUM_BW < DATA_BW + WEIGHT_BW) begin : g_bad_width
    $error("sa_row_ctrl: PARTIAL_SUM_BW narrower than one product");
  end

  assign accept = in_valid && in_ready;

  // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      we_rl     <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      num_vec_q <= '0;
      acc_cnt   <= '0;
      res_cnt   <= '0;
      WEIGHTS   <= '0;
    end else begin
      we_rl <= 1'b0;
      done  <= 1'b0;
      if (res_valid) res_cnt <= res_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD_W;
            num_vec_q <= num_vec;
            WEIGHTS   <= w_data;
            acc_cnt   <= '0;
            res_cnt   <= '0;
            we_rl     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD_W: begin
          if (num_vec_q == 8'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= STREAM;
            in_ready <= 1'b1;
          end
        end
        STREAM: begin
          if (accept) begin
            acc_cnt <= acc_cnt + 8'd1;
            if (acc_cnt + 8'd1 == num_vec_q) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (res_valid && (res_cnt + 8'd1 == num_vec_q)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane i is delayed by i+1 registers; idle cycles inject zeros that travel as bubbles.
  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    logic [DATA_BW-1:0] sr_q [i+1];

    // NOTE: the skew array is reset explicitly so DIN reads zero in every empty slot right after reset.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int k = 0; k <= i; k++) sr_q[k] <= '0;
      end else begin
        sr_q[0] <= accept ? in_data[(MATRIX_SIZE-1-i)*DATA_BW +: DATA_BW] : '0;
        for (int k = 1; k <= i; k++) sr_q[k] <= sr_q[k-1];
      end
    end

    assign DIN[(MATRIX_SIZE-1-i)*DATA_BW +: DATA_BW] = sr_q[i];
  end

  // One token stage per PE plus the input stage; the last stage is the row result strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) token_q <= '0;
    else       token_q <= {token_q[MATRIX_SIZE-1:0], accept};
  end

  assign res_valid = token_q[MATRIX_SIZE];

`ifdef SA_ROW_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == STREAM && !in_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_row_ctrl.sv
// Directed bench for sa_row_ctrl: a per-cycle vector table plus hand-written multi-cycle jobs.
module tb_sa_row_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  num_vec;
  logic [63:0] w_data;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        we_rl;
  logic [63:0] WEIGHTS;
  logic [63:0] DIN;
  logic        res_valid;
  logic        busy;
  logic        done;
`ifdef SA_ROW_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  sa_row_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .num_vec   (num_vec),
    .w_data    (w_data),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .we_rl     (we_rl),
    .WEIGHTS   (WEIGHTS),
    .DIN       (DIN),
    .res_valid (res_valid),
    .busy      (busy),
`ifdef SA_ROW_CTRL_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ctl = {we_rl, in_ready, busy, res_valid, done}
  typedef struct {
    logic       start;
    logic [7:0] nv;
    logic       vld;
    logic [4:0] ctl;
    logic [7:0] lane0;
    logic [7:0] lane7;
  } vec_t;

  vec_t tbl [17];

  // Runs one job from the start cycle (cycle 0) and records event cycles relative to it.
  task automatic run_job(input logic [7:0] nv, input logic [63:0] w, input logic [15:0] vpat,
                         input bit vcont, input bit poke, input int budget,
                         output int r_acc, output int r_rv, output int r_first_rv,
                         output int r_second_rv, output int r_last_rv,
                         output int r_done_cyc, output int r_ndone);
    int cyc;
    bit fin;
    r_acc = 0; r_rv = 0; r_first_rv = -1; r_second_rv = -1; r_last_rv = -1;
    r_done_cyc = -1; r_ndone = 0;
    @(negedge clk);
    start = 1'b1; num_vec = nv; w_data = w; in_valid = 1'b0;
    cyc = 0; fin = 1'b0;
    while (!fin) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (poke && cyc == 3) begin
        start = 1'b1; num_vec = 8'd99; w_data = ~w;
      end else begin
        start = 1'b0; num_vec = nv; w_data = w;
      end
      if (vcont)                    in_valid = 1'b1;
      else if (cyc >= 2 && cyc < 18) in_valid = vpat[cyc-2];
      else                          in_valid = 1'b0;
      if (in_valid && in_ready) r_acc++;
      if (res_valid) begin
        r_rv++;
        if (r_first_rv < 0)       r_first_rv = cyc;
        else if (r_second_rv < 0) r_second_rv = cyc;
        r_last_rv = cyc;
      end
      if (done) begin
        r_ndone++;
        if (r_done_cyc < 0) r_done_cyc = cyc;
      end
      if ((r_done_cyc >= 0 && cyc >= r_done_cyc + 3) || cyc >= budget) fin = 1'b1;
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    int acc, rv, frv, srv, lrv, dcyc, nd, extra;

    //       start nv    vld  ctl       lane0  lane7
    tbl[0]  = '{1'b1, 8'd1, 1'b1, 5'b00000, 8'd0, 8'd0};
    tbl[1]  = '{1'b0, 8'd1, 1'b1, 5'b10100, 8'd0, 8'd0};
    tbl[2]  = '{1'b0, 8'd1, 1'b1, 5'b01100, 8'd0, 8'd0};
    tbl[3]  = '{1'b0, 8'd1, 1'b1, 5'b00100, 8'd1, 8'd0};
    tbl[4]  = '{1'b0, 8'd1, 1'b1, 5'b00100, 8'd0, 8'd0};
    tbl[5]  = '{1'b0, 8'd1, 1'b1, 5'b00100, 8'd0, 8'd0};
    tbl[6]  = '{1'b0, 8'd1, 1'b1, 5'b00100, 8'd0, 8'd0};
    tbl[7]  = '{1'b0, 8'd1, 1'b1, 5'b00100, 8'd0, 8'd0};
    tbl[8]  = '{1'b0, 8'd1, 1'b1, 5'b00100, 8'd0, 8'd0};
    tbl[9]  = '{1'b0, 8'd1, 1'b1, 5'b00100, 8'd0, 8'd0};
    tbl[10] = '{1'b0, 8'd1, 1'b1, 5'b00100, 8'd0, 8'd8};
    tbl[11] = '{1'b0, 8'd1, 1'b1, 5'b00110, 8'd0, 8'd0};
    tbl[12] = '{1'b0, 8'd1, 1'b1, 5'b00101, 8'd0, 8'd0};
    // back-to-back: num_vec=0 job started in the cycle right after DONE
    tbl[13] = '{1'b1, 8'd0, 1'b0, 5'b00000, 8'd0, 8'd0};
    tbl[14] = '{1'b0, 8'd0, 1'b0, 5'b10100, 8'd0, 8'd0};
    tbl[15] = '{1'b0, 8'd0, 1'b0, 5'b00101, 8'd0, 8'd0};
    tbl[16] = '{1'b0, 8'd0, 1'b0, 5'b00000, 8'd0, 8'd0};

    rstn = 1'b0; start = 1'b0; num_vec = '0; in_valid = 1'b0;
    w_data  = {8{8'h01}};
    in_data = 64'h0102_0304_0506_0708;
    repeat (3) @(negedge clk);
    check("reset_ctl", {we_rl, in_ready, busy, res_valid, done}, 5'b00000);
    check("reset_din", DIN, 64'h0);
    check("reset_weights", WEIGHTS, 64'h0);
    rstn = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      start = tbl[i].start; num_vec = tbl[i].nv; in_valid = tbl[i].vld;
      check($sformatf("tbl_ctl[%0d]", i), {we_rl, in_ready, busy, res_valid, done}, tbl[i].ctl);
      check($sformatf("tbl_lane0[%0d]", i), DIN[63:56], tbl[i].lane0);
      check($sformatf("tbl_lane7[%0d]", i), DIN[7:0], tbl[i].lane7);
      if (i == 2) check("tbl_weights", WEIGHTS, {8{8'h01}});
    end
    start = 1'b0; in_valid = 1'b0;

    // Gapped stream: accepts at cycles 2,5,6,7 -> results at 11,14,15,16, done at 17.
    run_job(8'd4, 64'h1122_3344_5566_7788, 16'h0039, 1'b0, 1'b0, 200,
            acc, rv, frv, srv, lrv, dcyc, nd);
    check("gap_accepts", acc, 4);
    check("gap_res_count", rv, 4);
    check("gap_first_rv", frv, 11);
    check("gap_rv_spacing", srv - frv, 3);
    check("gap_last_rv", lrv, 16);
    check("gap_done_cyc", dcyc, 17);
    check("gap_done_count", nd, 1);
`ifdef SA_ROW_CTRL_STALL_CNT_EN
    check("gap_stall_cnt", stall_cnt, 16'd2);
`endif

    // start poked during STREAM with different num_vec and weights must be ignored.
    run_job(8'd3, 64'hA5A5_5A5A_0F0F_F0F0, 16'h0, 1'b1, 1'b1, 200,
            acc, rv, frv, srv, lrv, dcyc, nd);
    check("poke_accepts", acc, 3);
    check("poke_res_count", rv, 3);
    check("poke_done_cyc", dcyc, 14);
    check("poke_done_count", nd, 1);
    check("poke_weights", WEIGHTS, 64'hA5A5_5A5A_0F0F_F0F0);

    // Reset during DRAIN: accepts at 2,3, DRAIN from cycle 4, reset at cycle 6.
    @(negedge clk);
    start = 1'b1; num_vec = 8'd2; w_data = 64'hDEAD_BEEF_0123_4567; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("drain_state", {in_ready, busy}, 2'b01);
    rstn = 1'b0;
    #1;
    check("abort_ctl", {we_rl, in_ready, busy, res_valid, done}, 5'b00000);
    check("abort_din", DIN, 64'h0);
    check("abort_weights", WEIGHTS, 64'h0);
`ifdef SA_ROW_CTRL_STALL_CNT_EN
    check("abort_stall_cnt", stall_cnt, 16'd0);
`endif
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || res_valid || busy) extra++;
    end
    check("abort_no_activity", extra, 0);

    run_job(8'd1, {8{8'h01}}, 16'h0, 1'b1, 1'b0, 200, acc, rv, frv, srv, lrv, dcyc, nd);
    check("clean_accepts", acc, 1);
    check("clean_first_rv", frv, 11);
    check("clean_done_cyc", dcyc, 12);
    check("clean_done_count", nd, 1);

    // Maximum job: first accept at 2, done at 2 + 255 + 8 + 1 = 266.
    run_job(8'd255, 64'h0807_0605_0403_0201, 16'h0, 1'b1, 1'b0, 400,
            acc, rv, frv, srv, lrv, dcyc, nd);
    check("max_accepts", acc, 255);
    check("max_res_count", rv, 255);
    check("max_first_rv", frv, 11);
    check("max_contiguous", lrv - frv, 254);
    check("max_done_cyc", dcyc, 266);
    check("max_done_count", nd, 1);
`ifdef SA_ROW_CTRL_STALL_CNT_EN
    check("max_stall_cnt", stall_cnt, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
